// File: rtl/ram_2port_rw_ctrl.sv
// Fill / read-back / compare sequencer for a simple dual-port RAM
// (port A write, port B read, shared clock). Each run writes
// (addr + pass_cnt) to addresses 0..DEPTH-1, reads them back and counts
// words that differ from the pattern. pass_cnt advances once per finished
// run, so consecutive runs use different data.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for start; err/err_cnt hold last run's result
// ST_WRITE | DEPTH cycles, one port-A write per cycle, addr 0..DEPTH-1
// ST_READ  | DEPTH cycles, one port-B read per cycle, addr 0..DEPTH-1
// ST_DRAIN | RD_LAT cycles so the last read reaches the comparator
// ST_FIN   | one cycle; produces the done pulse and bumps pass_cnt
//
// Every output is a register fed from the current state, so the outputs
// trail the state by one clock.

module ram_2port_rw_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter int RD_LAT = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              start,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   err_cnt
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  LEN_M1   = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  DRAIN_M1 = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
  localparam logic [DATA_W-1:0] PASS_ONE = DATA_W'(1);
  localparam logic [ADDR_W:0]   ERR_ONE  = (ADDR_W + 1)'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_FIN
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;     // cycles remaining in the phase, minus one
  logic [ADDR_W-1:0]  idx, idx_nxt;     // address issued in the current phase
  logic [DATA_W-1:0]  pass_cnt;
  logic [RD_LAT-1:0]  pipe_vld;
  logic [DATA_W-1:0]  pipe_exp [RD_LAT];
  logic               mismatch;
  logic               run_go;

  // Address is zero-extended or truncated to the data width before the offset.
  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                input logic [DATA_W-1:0] p);
    return DATA_W'(a) + p;
  endfunction

  assign run_go   = (state == ST_IDLE) && start;
  assign mismatch = pipe_vld[RD_LAT-1] && (ram_rd_data != pipe_exp[RD_LAT-1]);

  // State, phase timer and address counter registers.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next-state logic; each phase ends when the down-counter reaches zero.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_WRITE;
          cnt_nxt   = LEN_M1;
          idx_nxt   = '0;
        end
      end
      ST_WRITE: begin
        cnt_nxt = cnt - CNT_ONE;
        idx_nxt = idx + IDX_ONE;
        if (cnt == '0) begin
          state_nxt = ST_READ;
          cnt_nxt   = LEN_M1;
          idx_nxt   = '0;
        end
      end
      ST_READ: begin
        cnt_nxt = cnt - CNT_ONE;
        idx_nxt = idx + IDX_ONE;
        if (cnt == '0) begin
          state_nxt = ST_DRAIN;
          cnt_nxt   = DRAIN_M1;
        end
      end
      ST_DRAIN: begin
        cnt_nxt = cnt - CNT_ONE;
        if (cnt == '0) state_nxt = ST_FIN;
      end
      ST_FIN: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Registered RAM strobes and status; addresses hold outside their phase.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ram_wr_en   <= 1'b0;
      ram_wr_addr <= '0;
      ram_wr_data <= '0;
      ram_rd_en   <= 1'b0;
      ram_rd_addr <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      ram_wr_en <= (state == ST_WRITE);
      ram_rd_en <= (state == ST_READ);
      busy      <= (state != ST_IDLE);
      done      <= (state == ST_FIN);
      if (state == ST_WRITE) begin
        ram_wr_addr <= idx;
        ram_wr_data <= pattern(idx, pass_cnt);
      end
      if (state == ST_READ) ram_rd_addr <= idx;
    end
  end

  // Run counter that offsets the data pattern; wraps at the data width.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) pass_cnt <= '0;
    else if (state == ST_FIN) pass_cnt <= pass_cnt + PASS_ONE;
  end

  // Expected-data pipe, aligned so its last stage lines up with ram_rd_data.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pipe_vld <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_exp[i] <= '0;
    end else begin
      pipe_vld[0] <= ram_rd_en;
      pipe_exp[0] <= pattern(ram_rd_addr, pass_cnt);
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_exp[i] <= pipe_exp[i-1];
      end
    end
  end

  // Mismatch flag and saturating count; both cleared when a run is accepted.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end else if (run_go) begin
      err     <= 1'b0;
      err_cnt <= '0;
    end else if (mismatch) begin
      err <= 1'b1;
      if (err_cnt != '1) err_cnt <= err_cnt + ERR_ONE;
    end
  end

endmodule

// File: tb/tb_ram_2port_rw_ctrl.sv
// Bench for ram_2port_rw_ctrl: three instances (DEPTH=32/RD_LAT=1,
// DEPTH=32/RD_LAT=2, DEPTH=1/RD_LAT=1), each with its own RAM model that
// has selectable latency and per-address read corruption.
module tb_ram_2port_rw_ctrl;

  localparam int NDUT = 3;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       start_v     [NDUT];
  logic       wr_en_v     [NDUT];
  logic [4:0] wr_addr_v   [NDUT];
  logic [7:0] wr_data_v   [NDUT];
  logic       rd_en_v     [NDUT];
  logic [4:0] rd_addr_v   [NDUT];
  logic [7:0] rd_data_v   [NDUT];
  logic       busy_v      [NDUT];
  logic       done_v      [NDUT];
  logic       err_v       [NDUT];
  logic [5:0] err_cnt_v   [NDUT];

  int         depth [NDUT] = '{32, 32, 1};
  int         rdlat [NDUT] = '{1, 2, 1};
  int         p     [NDUT];
  int         ram_lat [NDUT];
  bit  [31:0] cmask [NDUT];

  logic [7:0] mem [NDUT][32];
  logic [7:0] q1  [NDUT];
  logic [7:0] q2  [NDUT];

  int n_chk = 0;
  int n_bad = 0;

  ram_2port_rw_ctrl #(.ADDR_W(5), .DATA_W(8), .DEPTH(32), .RD_LAT(1)) dut_a (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start_v[0]),
    .ram_wr_en(wr_en_v[0]), .ram_wr_addr(wr_addr_v[0]), .ram_wr_data(wr_data_v[0]),
    .ram_rd_en(rd_en_v[0]), .ram_rd_addr(rd_addr_v[0]), .ram_rd_data(rd_data_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .err(err_v[0]), .err_cnt(err_cnt_v[0]));

  ram_2port_rw_ctrl #(.ADDR_W(5), .DATA_W(8), .DEPTH(32), .RD_LAT(2)) dut_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start_v[1]),
    .ram_wr_en(wr_en_v[1]), .ram_wr_addr(wr_addr_v[1]), .ram_wr_data(wr_data_v[1]),
    .ram_rd_en(rd_en_v[1]), .ram_rd_addr(rd_addr_v[1]), .ram_rd_data(rd_data_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .err(err_v[1]), .err_cnt(err_cnt_v[1]));

  ram_2port_rw_ctrl #(.ADDR_W(5), .DATA_W(8), .DEPTH(1), .RD_LAT(1)) dut_c (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start_v[2]),
    .ram_wr_en(wr_en_v[2]), .ram_wr_addr(wr_addr_v[2]), .ram_wr_data(wr_data_v[2]),
    .ram_rd_en(rd_en_v[2]), .ram_rd_addr(rd_addr_v[2]), .ram_rd_data(rd_data_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .err(err_v[2]), .err_cnt(err_cnt_v[2]));

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // RAM models: synchronous read, output forced to 0 when not reading,
  // corrupted words XORed with 0x5A, optional second output register.
  always @(posedge sys_clk) begin
    for (int i = 0; i < NDUT; i++) begin
      if (wr_en_v[i]) mem[i][wr_addr_v[i]] <= wr_data_v[i];
      q1[i] <= rd_en_v[i] ? (mem[i][rd_addr_v[i]] ^ (cmask[i][rd_addr_v[i]] ? 8'h5A : 8'h00))
                          : 8'h00;
      q2[i] <= q1[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NDUT; i++) rd_data_v[i] = (ram_lat[i] == 2) ? q2[i] : q1[i];
  end

  task automatic check_val(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One run on instance s. cont: start was already accepted on the last edge.
  // hold: leave start high throughout (and after) the run.
  task automatic run(input int s, input int n_err, input bit cont, input bit hold);
    int  d      = depth[s];
    int  lat    = rdlat[s];
    int  k_done = 0;
    int  nw     = 0;
    int  nr     = 0;
    int  nbusy  = 0;
    bit  pulse  = !hold && ($urandom_range(1, 0) == 1);
    int  pk     = $urandom_range(2 * d + lat - 1, 1);
    if (!cont) begin
      repeat ($urandom_range(3, 0)) @(negedge sys_clk);
      @(negedge sys_clk);
      start_v[s] = 1'b1;
      @(negedge sys_clk);
    end
    if (!hold) start_v[s] = 1'b0;
    for (int k = 1; k <= 200 && k_done == 0; k++) begin
      @(negedge sys_clk);
      if (!hold) start_v[s] = (pulse && k == pk);
      if (k == 1) begin
        check_val("busy_rise", busy_v[s], 1);
        check_val("err_clr", err_v[s], 0);
        check_val("err_cnt_clr", err_cnt_v[s], 0);
      end
      if (wr_en_v[s]) begin
        if (nw == 0) check_val("wr_first_cyc", k, 1);
        check_val("wr_addr", wr_addr_v[s], nw);
        check_val("wr_data", wr_data_v[s], (nw + p[s]) % 256);
        nw++;
      end
      if (rd_en_v[s]) begin
        if (nr == 0) check_val("rd_first_cyc", k, d + 1);
        check_val("rd_addr", rd_addr_v[s], nr);
        nr++;
      end
      if (busy_v[s]) nbusy++;
      if (done_v[s]) k_done = k;
    end
    check_val("done_cyc", k_done, 2 * d + lat + 1);
    check_val("n_wr", nw, d);
    check_val("n_rd", nr, d);
    check_val("busy_cyc", nbusy, 2 * d + lat + 1);
    check_val("err", err_v[s], (n_err != 0) ? 1 : 0);
    check_val("err_cnt", err_cnt_v[s], n_err);
    @(negedge sys_clk);
    check_val("done_fall", done_v[s], 0);
    check_val("busy_fall", busy_v[s], 0);
    p[s] = (p[s] + 1) % 256;
  endtask

  initial begin
    bit [31:0] m;
    int        kr;
    int        nd;
    sys_rst_n = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      start_v[i] = 1'b0;
      cmask[i]   = '0;
      p[i]       = 0;
      ram_lat[i] = rdlat[i];
    end
    repeat (3) @(negedge sys_clk);
    check_val("rst_busy", busy_v[0], 0);
    check_val("rst_done", done_v[0], 0);
    check_val("rst_err", err_v[0], 0);
    check_val("rst_err_cnt", err_cnt_v[0], 0);
    check_val("rst_wr_en", wr_en_v[0], 0);
    check_val("rst_rd_en", rd_en_v[0], 0);
    sys_rst_n = 1'b1;

    // Clean runs: data = addr, addr+1, addr+2.
    run(0, 0, 0, 0);
    run(0, 0, 0, 0);
    run(0, 0, 0, 0);

    // Single corrupted word, sticky result, then cleared by the next start.
    cmask[0] = 32'h0000_0020;
    run(0, 1, 0, 0);
    repeat (3) @(negedge sys_clk);
    check_val("err_hold", err_v[0], 1);
    check_val("err_cnt_hold", err_cnt_v[0], 1);
    cmask[0] = '0;
    run(0, 0, 0, 0);

    // Random corruption sets; expected count is the number of bad words.
    for (int r = 0; r < 4; r++) begin
      m = $urandom() & $urandom() & $urandom();
      cmask[0] = m;
      run(0, $countones(m), 0, 0);
    end
    cmask[0] = '0;

    // Two-cycle read latency, then a RAM that is one cycle too fast.
    run(1, 0, 0, 0);
    ram_lat[1] = 1;
    run(1, 32, 0, 0);
    ram_lat[1] = 2;
    run(1, 0, 0, 0);

    // Single-word runs.
    run(2, 0, 0, 0);
    cmask[2] = 32'h1;
    run(2, 1, 0, 0);
    cmask[2] = '0;
    run(2, 0, 0, 0);

    // start held high: the next run begins after one idle cycle.
    run(0, 0, 0, 1);
    run(0, 0, 1, 0);

    // Reset during READ: immediate clear, no done, pass counter back to 0.
    @(negedge sys_clk);
    start_v[0] = 1'b1;
    @(negedge sys_clk);
    start_v[0] = 1'b0;
    kr = $urandom_range(64, 33);
    repeat (kr) @(negedge sys_clk);
    check_val("pre_rst_rd_en", rd_en_v[0], 1);
    #2 sys_rst_n = 1'b0;
    #1;
    check_val("abort_busy", busy_v[0], 0);
    check_val("abort_done", done_v[0], 0);
    check_val("abort_rd_en", rd_en_v[0], 0);
    check_val("abort_rd_addr", rd_addr_v[0], 0);
    check_val("abort_wr_en", wr_en_v[0], 0);
    check_val("abort_wr_addr", wr_addr_v[0], 0);
    check_val("abort_wr_data", wr_data_v[0], 0);
    check_val("abort_err", err_v[0], 0);
    check_val("abort_err_cnt", err_cnt_v[0], 0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    nd = 0;
    repeat (80) begin
      @(negedge sys_clk);
      if (done_v[0]) nd++;
    end
    check_val("abort_no_done", nd, 0);
    check_val("abort_idle", busy_v[0], 0);
    for (int i = 0; i < NDUT; i++) p[i] = 0;
    run(0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
